// File: rtl/neural_pkg.sv
// neural_pkg: shared fixed-point types and helpers for the neural datapath.
//   q16_16_t : signed Q16.16 value (16 integer bits, 16 fraction bits)
//   Q_FRAC   : number of fraction bits
//   Q_ONE    : 1.0 in Q16.16
//   q_mul()  : Q16.16 x Q16.16 -> Q16.16, full 64-bit product, truncating
//              arithmetic shift by Q_FRAC, wraps on overflow.
package neural_pkg;

    typedef logic signed [31:0] q16_16_t;

    localparam int      Q_FRAC = 16;
    localparam q16_16_t Q_ONE  = 32'h0001_0000;

    // The 64-bit signed product is shifted right arithmetically, then the
    // low 32 bits are kept: this is product[47:16] with no rounding and no
    // saturation, so out-of-range results wrap.
    function automatic q16_16_t q_mul(input q16_16_t a, input q16_16_t b);
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return q16_16_t'(prod >>> Q_FRAC);
    endfunction

endpackage

// File: rtl/mult_pipe.sv
// mult_pipe: LATENCY-stage signed Q16.16 multiplier pipeline that carries a
// valid bit and an owner tag alongside the data.
//   clk, rst   : clock, asynchronous active-high reset (clears valid bits only)
//   in_valid   : a new operation enters the pipe this cycle
//   in_tag     : owner of the entering operation
//   in_a, in_b : Q16.16 operands
//   out_valid  : the last stage holds a result this cycle
//   out_tag    : owner of the result in the last stage
//   out_data   : Q16.16 product; holds the most recent result while out_valid=0
//   any_valid  : at least one stage holds an operation
module mult_pipe
    import neural_pkg::*;
#(
    parameter int TAG_W   = 2,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  q16_16_t          in_a,
    input  q16_16_t          in_b,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output q16_16_t          out_data,
    output logic             any_valid
);

    logic [LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];

    // Only the valid bits are reset; tags and data are don't-care while
    // their valid bit is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_q[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    generate
        if (LATENCY == 1) begin : g_single
            // Single stage: multiply in front of the only register.
            q16_16_t prod_q;

            always_ff @(posedge clk) begin
                if (in_valid) begin
                    prod_q <= q_mul(in_a, in_b);
                end
            end

            assign out_data = prod_q;
        end else begin : g_multi
            // Stage 0 registers the operands so the granted-operand mux and
            // the multiplier sit in different cycles; later stages only delay.
            q16_16_t op_a_q;
            q16_16_t op_b_q;
            q16_16_t dat_q [1:LATENCY-1];

            always_ff @(posedge clk) begin
                if (in_valid) begin
                    op_a_q <= in_a;
                    op_b_q <= in_b;
                end
                if (vld_q[0]) begin
                    dat_q[1] <= q_mul(op_a_q, op_b_q);
                end
                for (int i = 2; i < LATENCY; i++) begin
                    if (vld_q[i-1]) begin
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign out_data = dat_q[LATENCY-1];
        end
    endgenerate

    assign out_valid = vld_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin scheduler sharing one pipelined Q16.16
// multiplier among N_REQ requesters.
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : per-requester request valid
//   req_a/req_b : per-requester Q16.16 operands
//   req_ready   : one-hot or zero grant for this cycle
//   rsp_valid   : one-hot or zero owner of rsp_data this cycle
//   rsp_data    : Q16.16 product; holds its last value while rsp_valid=0
//   idle        : nothing in flight and no requester busy
//
// Handshake: a request is accepted in a cycle where req_valid[i] and
// req_ready[i] are both high. The requester holds req_valid, req_a and req_b
// stable until accepted. req_ready never depends on req_a/req_b. Responses
// have no backpressure: rsp_valid[i] is high for exactly one cycle,
// LATENCY cycles after the accept, and the requester must capture it then.
module mult_scheduler
    import neural_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0][31:0] req_a,
    input  logic [N_REQ-1:0][31:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   idle
);

    localparam int TAG_W = $clog2(N_REQ);

    logic [N_REQ-1:0] busy_q;
    logic [TAG_W-1:0] ptr_q;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [TAG_W-1:0] gnt_tag;
    logic             gnt_found;
    logic [TAG_W-1:0] ptr_next;

    logic             pipe_valid;
    logic [TAG_W-1:0] pipe_tag;
    q16_16_t          pipe_data;
    logic             pipe_any;
    q16_16_t          rsp_hold_q;

    // A requester with an operation in flight may not be granted again, so
    // each requester has at most one outstanding result.
    assign eligible = req_valid & ~busy_q;

    // Round-robin search starting at ptr_q; the first eligible index wins.
    always_comb begin
        logic [TAG_W:0]   cand_sum;
        logic [TAG_W-1:0] cand;
        grant     = '0;
        gnt_tag   = '0;
        gnt_found = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (cand_sum >= (TAG_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (TAG_W+1)'(N_REQ);
            end
            cand = cand_sum[TAG_W-1:0];
            if (!gnt_found && eligible[cand]) begin
                grant[cand] = 1'b1;
                gnt_tag     = cand;
                gnt_found   = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    // Pointer moves just past the granted index, wrapping at N_REQ-1.
    assign ptr_next = (gnt_tag == TAG_W'(N_REQ - 1)) ? '0 : gnt_tag + TAG_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (gnt_found) begin
            ptr_q <= ptr_next;
        end
    end

    // Busy is set by the accept and dropped after the response cycle. The
    // same requester cannot be both granted and responding in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~rsp_valid) | grant;
        end
    end

    mult_pipe #(
        .TAG_W   (TAG_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (gnt_found),
        .in_tag    (gnt_tag),
        .in_a      (q16_16_t'(req_a[gnt_tag])),
        .in_b      (q16_16_t'(req_b[gnt_tag])),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_data  (pipe_data),
        .any_valid (pipe_any)
    );

    // Response demux: one-hot owner from the tag of the last stage.
    always_comb begin
        rsp_valid = '0;
        if (pipe_valid) begin
            rsp_valid[pipe_tag] = 1'b1;
        end
    end

    // The pipe's data registers are not reset, so a separate holding
    // register gives rsp_data its reset value of zero and keeps the last
    // product between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_hold_q <= '0;
        end else if (pipe_valid) begin
            rsp_hold_q <= pipe_data;
        end
    end

    assign rsp_data = pipe_valid ? pipe_data : rsp_hold_q;
    assign idle     = !pipe_any && (busy_q == '0);

endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed and randomized checks of mult_scheduler with a
// scoreboard. A monitor at the falling edge predicts grants from a
// round-robin reference model, pushes expected responses on each predicted
// accept and pops/compares them when the DUT presents a response.
module tb_mult_scheduler;

    localparam int N     = 4;
    localparam int LAT   = 2;
    localparam int LIMIT = N * (LAT + 1);
    localparam int LOGN  = 64;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0][31:0]   req_a;
    logic [N-1:0][31:0]   req_b;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [31:0]          rsp_data;
    logic                 idle;

    mult_scheduler #(.N_REQ(N), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .idle      (idle)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // expected entry: {due cycle[71:40], owner[39:32], product[31:0]}
    logic [71:0] exp_q[$];

    int m_ptr;
    int m_busy_until [N];
    int wait_cnt     [N];
    bit acc_flag     [N];
    int cyc;

    int          g_log [LOGN];
    int          r_log [LOGN];
    logic [31:0] d_log [LOGN];
    logic        i_log [LOGN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Reference product: exact 64-bit signed product, arithmetic shift by 16,
    // keep the low 32 bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 16;
        return p[31:0];
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        int          g;
        int          idx;
        bit          exp_idle;
        logic [71:0] e;
        if (rst) begin
            check("rst_req_ready", 64'(req_ready), 64'(0));
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_rsp_data", 64'(rsp_data), 64'(0));
            check("rst_idle", 64'(idle), 64'(1));
            m_ptr = 0;
            cyc   = 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) begin
                m_busy_until[i] = -1;
                wait_cnt[i]     = 0;
                acc_flag[i]     = 1'b0;
            end
            for (int i = 0; i < LOGN; i++) begin
                g_log[i] = -1;
                r_log[i] = -1;
                d_log[i] = 'x;
                i_log[i] = 'x;
            end
        end else begin
            // predicted grant: first requester from m_ptr that is valid and free
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx] && m_busy_until[idx] < cyc) g = idx;
            end
            check("req_ready", 64'(req_ready), 64'(onehot(g)));
            check("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));

            exp_idle = 1'b1;
            for (int i = 0; i < N; i++) if (m_busy_until[i] >= cyc) exp_idle = 1'b0;
            check("idle", 64'(idle), 64'(exp_idle));

            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(e[71:40]));
                    check("rsp_owner", 64'(rsp_valid), 64'(onehot(int'(e[39:32]))));
                    check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][71:40]) <= cyc) begin
                e = exp_q.pop_front();
                check("missing_rsp", 64'(rsp_valid), 64'(onehot(int'(e[39:32]))));
            end

            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && g != i) begin
                    wait_cnt[i]++;
                    check("starvation", 64'(wait_cnt[i] < LIMIT), 64'(1));
                end else begin
                    wait_cnt[i] = 0;
                end
            end

            if (cyc < LOGN) begin
                g_log[cyc] = oh_idx(req_ready);
                r_log[cyc] = oh_idx(rsp_valid);
                d_log[cyc] = rsp_data;
                i_log[cyc] = idle;
            end

            if (g >= 0) begin
                exp_q.push_back({32'(cyc + LAT), 8'(g), ref_mul(req_a[g], req_b[g])});
                m_busy_until[g] = cyc + LAT;
                m_ptr           = (g + 1) % N;
                acc_flag[g]     = 1'b1;
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i]     = a;
        req_b[i]     = b;
        req_valid[i] = 1'b1;
    endtask

    // advance one cycle and drop requests the reference model saw accepted
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i]  = 1'b0;
                req_valid[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom();
            1: v = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
            2: v = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: v = 32'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    int exp_fair [7] = '{1, 3, -1, 1, 3, -1, 1};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // single op with defaults
        do_reset();
        issue(0, 32'h0002_0000, 32'h0001_8000);
        repeat (5) step();
        check("t1_grant0", 64'(g_log[0]), 64'(0));
        check("t1_rsp_owner", 64'(r_log[2]), 64'(0));
        check("t1_rsp_data", 64'(d_log[2]), 64'h0003_0000);
        check("t1_busy_idle", 64'(i_log[2]), 64'(0));
        check("t1_idle", 64'(i_log[3]), 64'(1));
        check("t1_data_hold", 64'(d_log[3]), 64'h0003_0000);

        // sign and truncation
        do_reset();
        issue(1, 32'hFFFF_0000, 32'h0000_4000);
        issue(2, 32'h0000_0001, 32'h0000_0001);
        repeat (6) step();
        check("t2_grant0", 64'(g_log[0]), 64'(1));
        check("t2_grant1", 64'(g_log[1]), 64'(2));
        check("t2_neg_owner", 64'(r_log[2]), 64'(1));
        check("t2_neg_data", 64'(d_log[2]), 64'hFFFF_C000);
        check("t2_trunc_owner", 64'(r_log[3]), 64'(2));
        check("t2_trunc_data", 64'(d_log[3]), 64'h0000_0000);

        // all four requesters at once
        do_reset();
        for (int i = 0; i < N; i++) issue(i, rand_op(), rand_op());
        repeat (8) step();
        for (int i = 0; i < N; i++) begin
            check("t3_grant", 64'(g_log[i]), 64'(i));
            check("t3_rsp_owner", 64'(r_log[i + 2]), 64'(i));
        end

        // fairness with busy: 1 and 3 held valid continuously
        do_reset();
        issue(1, rand_op(), rand_op());
        issue(3, rand_op(), rand_op());
        for (int c = 0; c < 8; c++) begin
            step();
            if (!req_valid[1]) issue(1, rand_op(), rand_op());
            if (!req_valid[3]) issue(3, rand_op(), rand_op());
        end
        for (int c = 0; c < 7; c++) check("t4_grant_seq", 64'(g_log[c]), 64'(exp_fair[c]));
        req_valid = '0;

        // reset mid-flight
        do_reset();
        issue(2, 32'h0003_0000, 32'h0002_0000);
        step();
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) step();
        issue(0, 32'h0001_0000, 32'h0001_0000);
        issue(3, 32'h0001_0000, 32'h0001_0000);
        repeat (4) step();
        for (int c = 0; c < 5; c++) check("t5_no_rsp", 64'(r_log[c]), 64'(-1));
        check("t5_idle", 64'(i_log[0]), 64'(1));
        check("t5_grant_from0", 64'(g_log[5]), 64'(0));
        check("t5_grant_next", 64'(g_log[6]), 64'(3));
        req_valid = '0;

        // randomized stress
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) issue(i, rand_op(), rand_op());
            end
            step();
        end
        repeat (40) step();
        check("drain_queue", 64'(exp_q.size()), 64'(0));
        check("drain_idle", 64'(idle), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
